// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the RV32I 5-stage pipeline: stage enables,
// flushes and bubbles, a data-memory wait watchdog and saturating perf counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       halted_reg, halted_next;
  logic       mem_stall, load_use;
  logic       branch_acc, load_use_acc;
  logic [1:0] cnt_inc;

  assign mem_stall = mem_req && !dmem_ready;
  assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    memwb_bubble  = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    halted_next   = halted_reg;
    branch_acc    = 1'b0;
    load_use_acc  = 1'b0;

    if (!rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (state_reg == HALT) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else begin
      // A stalled MEM freezes EX, so a pending branch stays visible until the stall clears.
      if (mem_stall) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        branch_acc = 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_flush   = 1'b1;
        load_use_acc = 1'b1;
      end

      case (state_reg)
        RUN: begin
          if (mem_stall) begin
            state_next    = MEM_WAIT;
            wait_cnt_next = 8'd1;
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state_next    = RUN;
            wait_cnt_next = 8'd0;
          end else if (wait_cnt_reg == TIMEOUT) begin
            state_next  = HALT;
            halted_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      halted_reg   <= halted_next;
    end
  end

  assign cnt_inc[0] = (state_reg == HALT) || mem_stall || load_use_acc;
  assign cnt_inc[1] = branch_acc;

  // Index 0 counts stall cycles, index 1 counts accepted branch flushes.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign halted      = halted_reg;
  assign stall_count = gen_cnt[0].cnt_reg;
  assign flush_count = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table vectors, directed corner sequences
// and randomized traffic checked against a stall-streak reference model.
module tb_pipeline_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  // Control vector order: {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb, memwb_bubble}
  localparam logic [7:0] C_NORMAL = 8'b11010110;
  localparam logic [7:0] C_BRANCH = 8'b11111110;
  localparam logic [7:0] C_LDUSE  = 8'b00011110;
  localparam logic [7:0] C_MSTALL = 8'b00000011;
  localparam logic [7:0] C_HALT   = 8'b00000001;
  localparam logic [7:0] C_RESET  = 8'b00101001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, mem_req, dmem_ready;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble;
  logic halted;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [7:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: length of the current uninterrupted stall streak, halt flag, counters.
  int m_streak = 0;
  int m_halted = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .memwb_bubble(memwb_bubble), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble};

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, req, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic do_cycle(input string tag, input bit use_tab, input logic [7:0] tab_exp);
    logic ms, lu;
    logic [7:0] exp;
    #4;
    ms = mem_req && !dmem_ready;
    lu = ex_memread && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!rst)                 exp = C_RESET;
    else if (m_halted != 0)   exp = C_HALT;
    else if (ms)              exp = C_MSTALL;
    else if (ex_branch_taken) exp = C_BRANCH;
    else if (lu)              exp = C_LDUSE;
    else                      exp = C_NORMAL;
    check({tag, " ctrl"}, 32'(ctrl), 32'(exp));
    if (use_tab) check({tag, " table_ctrl"}, 32'(ctrl), 32'(tab_exp));
    @(posedge clk);
    if (!rst) begin
      m_streak = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else if (m_halted != 0) begin
      if (m_stall < MAXC) m_stall++;
    end else begin
      if ((ms || (lu && !ex_branch_taken)) && m_stall < MAXC) m_stall++;
      if (!ms && ex_branch_taken && m_flush < MAXC) m_flush++;
      if (ms) begin
        m_streak++;
        if (m_streak == TO + 1) m_halted = 1;
      end else begin
        m_streak = 0;
      end
    end
    #1;
    check({tag, " halted"}, 32'(halted), 32'(m_halted));
    check({tag, " stall_count"}, 32'(stall_count), 32'(m_stall));
    check({tag, " flush_count"}, 32'(flush_count), 32'(m_flush));
    $display("[TB] %s ctrl=%b halted=%0d stall=%0d flush=%0d", tag, ctrl, halted, stall_count, flush_count);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    set_idle();
    rst = 1'b0;
    do_cycle("reset", 1'b1, C_RESET);
    rst = 1'b1;
  endtask

  initial begin
    //            rs1    rs2    u1    u2    rd     mr    br    req   rdy   exp
    vecs[0] = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, C_LDUSE};
    vecs[1] = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_NORMAL};
    vecs[2] = '{5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, C_BRANCH};
    vecs[3] = '{5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, C_NORMAL};
    vecs[4] = '{5'd9, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, C_NORMAL};
    vecs[5] = '{5'd31, 5'd3, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, C_LDUSE};
    vecs[6] = '{5'd4, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, C_NORMAL};
    vecs[7] = '{5'd8, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, C_MSTALL};
    vecs[8] = '{5'd8, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, C_NORMAL};
    vecs[9] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, C_BRANCH};

    set_idle();
    @(negedge clk);

    reset_dut();
    check("reset halted", 32'(halted), 32'd0);
    check("reset stall_count", 32'(stall_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_rd = vecs[i].rd; ex_memread = vecs[i].mr; ex_branch_taken = vecs[i].br;
      mem_req = vecs[i].req; dmem_ready = vecs[i].rdy;
      do_cycle($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
    end

    // Load-use inserts exactly one bubble, then the load has moved on.
    reset_dut();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    do_cycle("lu_stall", 1'b1, C_LDUSE);
    check("lu stall_count", 32'(stall_count), 32'd1);
    ex_memread = 1'b0; mem_req = 1'b1; dmem_ready = 1'b1;
    do_cycle("lu_release", 1'b1, C_NORMAL);

    // Branch beats a coinciding load-use.
    reset_dut();
    ex_memread = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1;
    do_cycle("br_over_lu", 1'b1, C_BRANCH);
    check("br_over_lu flush_count", 32'(flush_count), 32'd1);
    check("br_over_lu stall_count", 32'(stall_count), 32'd0);

    // Three-cycle memory wait, then completion.
    reset_dut();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_cycle($sformatf("mwait%0d", i), 1'b1, C_MSTALL);
    dmem_ready = 1'b1;
    do_cycle("mwait_done", 1'b1, C_NORMAL);
    check("mwait stall_count", 32'(stall_count), 32'd3);

    // Watchdog: one RUN plus TO MEM_WAIT stall cycles halts the core.
    reset_dut();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO; i++) do_cycle($sformatf("wdog%0d", i), 1'b1, C_MSTALL);
    check("wdog not yet halted", 32'(halted), 32'd0);
    do_cycle("wdog_last", 1'b1, C_MSTALL);
    check("wdog halted", 32'(halted), 32'd1);
    dmem_ready = 1'b1; ex_branch_taken = 1'b1;
    do_cycle("halt_frozen0", 1'b1, C_HALT);
    mem_req = 1'b0; ex_branch_taken = 1'b0;
    do_cycle("halt_frozen1", 1'b1, C_HALT);
    check("halt stall_count", 32'(stall_count), 32'd7);
    check("halt flush_count", 32'(flush_count), 32'd0);
    rst = 1'b0;
    do_cycle("halt_reset", 1'b1, C_RESET);
    check("halt_reset halted", 32'(halted), 32'd0);
    check("halt_reset stall_count", 32'(stall_count), 32'd0);
    rst = 1'b1;
    do_cycle("after_halt", 1'b1, C_NORMAL);

    // Branch held across a two-cycle memory stall, flushed exactly once.
    reset_dut();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    do_cycle("br_hold0", 1'b1, C_MSTALL);
    do_cycle("br_hold1", 1'b1, C_MSTALL);
    check("br_hold flush_count", 32'(flush_count), 32'd0);
    dmem_ready = 1'b1;
    do_cycle("br_release", 1'b1, C_BRANCH);
    check("br_release flush_count", 32'(flush_count), 32'd1);

    // Randomized traffic with bursty memory latency and occasional resets.
    begin
      bit slow = 1'b0;
      for (int n = 0; n < 1200; n++) begin
        if ($urandom_range(0, 19) == 0) slow = !slow;
        rst             = ($urandom_range(0, 59) != 0);
        id_rs1          = 5'($urandom_range(0, 3));
        id_rs2          = 5'($urandom_range(0, 3));
        ex_rd           = 5'($urandom_range(0, 3));
        id_uses_rs1     = 1'($urandom_range(0, 1));
        id_uses_rs2     = 1'($urandom_range(0, 1));
        ex_memread      = 1'($urandom_range(0, 1));
        ex_branch_taken = ($urandom_range(0, 4) == 0);
        mem_req         = ($urandom_range(0, 9) < (slow ? 9 : 4));
        dmem_ready      = ($urandom_range(0, 9) < (slow ? 1 : 7));
        do_cycle($sformatf("rnd%0d", n), 1'b0, 8'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
